// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder slice iterated WIDTH cycles, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_addsub_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic               ha1_s, ha1_c, ha2_c, sum_s, cout_s;

  // Next-state, datapath shift and full-adder slice for the current bit.
  always_comb begin
    // Slice: two half adders plus an OR of their carries.
    ha1_s  = a_q[0] ^ b_q[0];
    ha1_c  = a_q[0] & b_q[0];
    sum_s  = ha1_s ^ c_q;
    ha2_c  = ha1_s & c_q;
    cout_s = ha1_c | ha2_c;

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = val1;
          b_d     = op_sub ? ~val2 : val2;
          c_d     = op_sub;
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        c_d   = cout_s;
        res_d = {sum_s, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // c_q is the carry into the MSB on this final bit.
          ovf_d   = c_q ^ cout_s;
          carry_d = cout_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      c_q         <= 1'b0;
      res_q       <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = res_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule
